// File: rtl/serial_adder_n.sv
// Multi-cycle adder: adds SLICE bits per clock, LSB slice first, with a valid/ready handshake on both sides.
// Optional SERIAL_ADDER_SUB_EN adds a sub port that turns the block into an A - B subtractor.
module serial_adder_n #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] s_shift;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction is A + ~B + 1, so the operand and carry are conditioned at capture time.
    always_comb begin
        b_in = in_2;
        c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in = ~in_2;
            c_in = 1'b1;
        end
`endif
    end

    // Operands shift right one slice per cycle, so the active slice is always the low SLICE bits;
    // the result shifts in from the top and is fully aligned after NSL slices.
    always_comb begin
        slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};
        s_shift = s_q >> SLICE;
        s_shift[WIDTH-1 -: SLICE] = slice_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_1;
                        b_q        <= b_in;
                        carry_q    <= c_in;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    carry_q <= slice_sum[SLICE];
                    s_q     <= s_shift;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_sum[SLICE];
                        ovf_q       <= signed_ovf(a_q[SLICE-1], b_q[SLICE-1], slice_sum[SLICE-1]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n (WIDTH=16, SLICE=4): directed vectors, handshake/reset
// corner sequences and randomized operations against an arithmetic reference model.
module tb_serial_adder_n;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_n #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_1      (in_1),
        .in_2      (in_2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sb;
        int          hold;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-precision integer arithmetic; overflow is the signed result leaving 16-bit range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                         output logic [15:0] es, output logic ec, output logic eo);
        logic [15:0] bb;
        int          cc;
        int          full;
        int          ssum;
        bb   = sb ? ~b : b;
        cc   = sb ? 1 : int'(c);
        full = int'(a) + int'(bb) + cc;
        ssum = int'($signed(a)) + int'($signed(bb)) + cc;
        es   = full[15:0];
        ec   = (full > 65535);
        eo   = (ssum > 32767) || (ssum < -32768);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                         input int hold, input bit noise,
                         input logic [15:0] es, input logic ec, input logic eo, input string tag);
        int w;
        int n;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        in_1 = a;
        in_2 = b;
        cin  = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub  = sb;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready_after_accept"}, 32'(in_ready), 32'd0);
        in_valid = noise;
        if (noise) begin
            in_1 = 16'($urandom);
            in_2 = 16'($urandom);
            cin  = 1'($urandom);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            if (noise) out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(NSL));
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_s"}, 32'(s), 32'(es));
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic [15:0] es;
        logic        ec;
        logic        eo;

        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h000B, 16'h0005, 1'b1, 1'b0, 3, 16'h0011, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 2, 16'h1000, 1'b0, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 16'h8000, 1'b0, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_1      = '0;
        in_2      = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_1     = 16'h00AA;
        #1;
        chk("ready_low_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_high_after_first_edge", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sb, vecs[i].hold, 1'b0,
                  vecs[i].es, vecs[i].ec, vecs[i].eo, $sformatf("vec%0d", i));

        // Reset in the second RUN cycle, with cout/ovf left set by the previous result.
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b1, "pre_reset");
        in_1 = 16'h1111;
        in_2 = 16'h2222;
        cin  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub  = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_s", 32'(s), 32'd0);
        chk("midrun_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) chk("midrun_no_result", 32'(out_valid), 32'd0);
        end
        chk("midrun_idle_ready", 32'(in_ready), 32'd1);
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 1'b0, 16'h3333, 1'b0, 1'b0, "post_reset");

        // Random operations with in_valid/out_ready noise while busy.
        for (int r = 0; r < 40; r++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (r % 8 == 0) ra = 16'h7FFF;
            if (r % 8 == 1) rb = 16'h8000;
            model(ra, rb, rc, rs, es, ec, eo);
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), 1'b1, es, ec, eo, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
